// File: rtl/uart_cmd_responder.sv
// Byte-level request/reply responder: 5-byte request frames drive a 15x8 register file, 4-byte replies.
// Optional inter-byte timeout abort is compiled in with UART_RSP_TIMEOUT_EN.
module uart_cmd_responder #(
    parameter logic [31:0] TIMEOUT_CYC = 32'd5_000_000
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [7:0]   RX_DATA,
    input  logic         RX_RECV,
    output logic [7:0]   TX_DATA,
    output logic         TX_START,
    input  logic         TX_BUSY,
    input  logic [7:0]   STATUS_IN,
    output logic [119:0] REGS_OUT,
    output logic         WR_STROBE,
    output logic [3:0]   WR_ADDR,
    output logic         FRAME_ERR,
    output logic         BUSY
);

    typedef enum logic [3:0] {
        IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CHK,
        EXEC, TX_LOAD, TX_WAITHI, TX_WAITLO
    } state_t;

    localparam logic [7:0] SOF_REQ = 8'hA5;
    localparam logic [7:0] SOF_RSP = 8'h5A;
    localparam logic [7:0] CMD_RD  = 8'h01;
    localparam logic [7:0] CMD_WR  = 8'h02;

    state_t     state_q, state_d;
    logic [7:0] cmd_q, cmd_d, addr_q, addr_d;
    logic [7:0] data_q, data_d, chk_q, chk_d;
    logic [7:0] stat_q, stat_d, rdat_q, rdat_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_start_q, tx_start_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic       frame_err_q, frame_err_d;
    logic [3:0] wr_addr_q, wr_addr_d;
    logic [7:0] regs_q [16];
    logic [7:0] regs_d [16];
    logic [7:0] exec_stat, exec_rdat, reply_byte;
    logic       timeout;

`ifdef UART_RSP_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if ((state_q inside {GET_CMD, GET_ADDR, GET_DATA, GET_CHK}) && !RX_RECV)
            cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign timeout = (cnt_d == TIMEOUT_CYC);
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign timeout = 1'b0;
`endif

    // Status priority: checksum, command, address range, read-only target
    always_comb begin
        exec_stat = 8'h00;
        exec_rdat = 8'h00;
        if ((cmd_q ^ addr_q ^ data_q) != chk_q)
            exec_stat = 8'h04;
        else if (cmd_q != CMD_RD && cmd_q != CMD_WR)
            exec_stat = 8'h01;
        else if (addr_q > 8'h0F)
            exec_stat = 8'h03;
        else if (cmd_q == CMD_WR && addr_q[3:0] == 4'hF)
            exec_stat = 8'h02;
        if (exec_stat == 8'h00) begin
            if (cmd_q == CMD_WR)
                exec_rdat = data_q;
            else if (addr_q[3:0] == 4'hF)
                exec_rdat = STATUS_IN;
            else
                exec_rdat = regs_q[addr_q[3:0]];
        end
    end

    always_comb begin
        reply_byte = SOF_RSP;
        unique case (idx_q)
            2'd0: reply_byte = SOF_RSP;
            2'd1: reply_byte = stat_q;
            2'd2: reply_byte = rdat_q;
            2'd3: reply_byte = stat_q ^ rdat_q;
            default: reply_byte = SOF_RSP;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        data_d      = data_q;
        chk_d       = chk_q;
        stat_d      = stat_q;
        rdat_d      = rdat_q;
        idx_d       = idx_q;
        tx_data_d   = tx_data_q;
        wr_addr_d   = wr_addr_q;
        regs_d      = regs_q;
        tx_start_d  = 1'b0;
        wr_strobe_d = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            IDLE:
                if (RX_RECV && RX_DATA == SOF_REQ) state_d = GET_CMD;
            GET_CMD:
                if (RX_RECV) begin
                    cmd_d   = RX_DATA;
                    state_d = GET_ADDR;
                end
            GET_ADDR:
                if (RX_RECV) begin
                    addr_d  = RX_DATA;
                    state_d = GET_DATA;
                end
            GET_DATA:
                if (RX_RECV) begin
                    data_d  = RX_DATA;
                    state_d = GET_CHK;
                end
            GET_CHK:
                if (RX_RECV) begin
                    chk_d   = RX_DATA;
                    state_d = EXEC;
                end
            EXEC: begin
                stat_d  = exec_stat;
                rdat_d  = exec_rdat;
                idx_d   = 2'd0;
                state_d = TX_LOAD;
                if (exec_stat == 8'h00 && cmd_q == CMD_WR) begin
                    regs_d[addr_q[3:0]] = data_q;
                    wr_strobe_d         = 1'b1;
                    wr_addr_d           = addr_q[3:0];
                end
                if (exec_stat == 8'h04) frame_err_d = 1'b1;
            end
            TX_LOAD:
                if (!TX_BUSY) begin
                    tx_data_d  = reply_byte;
                    tx_start_d = 1'b1;
                    state_d    = TX_WAITHI;
                end
            TX_WAITHI:
                if (TX_BUSY) state_d = TX_WAITLO;
            TX_WAITLO:
                if (!TX_BUSY) begin
                    if (idx_q == 2'd3) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = TX_LOAD;
                    end
                end
            default: state_d = IDLE;
        endcase
        // Only asserted in GET_* with no byte arriving this cycle
        if (timeout) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            chk_q       <= '0;
            stat_q      <= '0;
            rdat_q      <= '0;
            idx_q       <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= '0;
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            chk_q       <= chk_d;
            stat_q      <= stat_d;
            rdat_q      <= rdat_d;
            idx_q       <= idx_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            wr_strobe_q <= wr_strobe_d;
            frame_err_q <= frame_err_d;
            wr_addr_q   <= wr_addr_d;
            regs_q      <= regs_d;
        end
    end

    for (genvar g = 0; g < 15; g++) begin : g_regs_out
        assign REGS_OUT[8*g +: 8] = regs_q[g];
    end

    assign TX_DATA   = tx_data_q;
    assign TX_START  = tx_start_q;
    assign WR_STROBE = wr_strobe_q;
    assign WR_ADDR   = wr_addr_q;
    assign FRAME_ERR = frame_err_q;
    assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: table of request/reply vectors plus
// hand-written sequences for busy hold, RX during reply, reset mid-reply and timeout.
module tb_uart_cmd_responder;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic [7:0]   RX_DATA = 8'h00;
    logic         RX_RECV = 1'b0;
    logic [7:0]   TX_DATA;
    logic         TX_START;
    logic         TX_BUSY = 1'b0;
    logic [7:0]   STATUS_IN = 8'h00;
    logic [119:0] REGS_OUT;
    logic         WR_STROBE;
    logic [3:0]   WR_ADDR;
    logic         FRAME_ERR;
    logic         BUSY;

    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    uart_cmd_responder #(.TIMEOUT_CYC(32'd100)) dut (
        .CLK(CLK), .RST_N(RST_N), .RX_DATA(RX_DATA), .RX_RECV(RX_RECV),
        .TX_DATA(TX_DATA), .TX_START(TX_START), .TX_BUSY(TX_BUSY),
        .STATUS_IN(STATUS_IN), .REGS_OUT(REGS_OUT), .WR_STROBE(WR_STROBE),
        .WR_ADDR(WR_ADDR), .FRAME_ERR(FRAME_ERR), .BUSY(BUSY)
    );

    // Simple uart_tx stand-in: captures bytes, stays busy 20 cycles per byte
    logic [7:0] txq[$];
    int   n_start = 0, n_wr = 0, n_ferr = 0, busy_cnt = 0;
    bit   hold_busy = 1'b0, tx_unstable = 1'b0;
    logic [7:0] tx_hold = 8'h00;

    always @(negedge CLK) begin
        if (TX_START) begin
            txq.push_back(TX_DATA);
            n_start++;
            busy_cnt = 20;
            tx_hold = TX_DATA;
        end else if (busy_cnt > 0 && TX_DATA !== tx_hold) begin
            tx_unstable = 1'b1;
        end
        if (WR_STROBE) n_wr++;
        if (FRAME_ERR) n_ferr++;
        if (hold_busy) TX_BUSY = 1'b1;
        else if (busy_cnt > 0) begin
            TX_BUSY = 1'b1;
            busy_cnt--;
        end else TX_BUSY = 1'b0;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [119:0] act, input logic [119:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_DATA = b;
        RX_RECV = 1'b1;
        @(negedge CLK);
        RX_RECV = 1'b0;
        @(negedge CLK);
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (!BUSY && busy_cnt == 0) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge CLK);
    endtask

    task automatic check_reply(input string tag, input logic [31:0] rep);
        logic [7:0] act;
        check({tag, "_ntx"}, 120'(txq.size()), 120'd4);
        for (int b = 0; b < 4; b++) begin
            act = (txq.size() > b) ? txq[b] : 8'hxx;
            check($sformatf("%s_b%0d", tag, b), 120'(act), 120'(rep[8*(3-b) +: 8]));
        end
        check({tag, "_txhold"}, 120'(tx_unstable), 120'd0);
    endtask

    typedef struct packed {
        logic [39:0] req;
        logic [7:0]  sts;
        logic [31:0] rep;
        logic        wr;
        logic        ferr;
        logic [3:0]  ridx;
        logic [7:0]  rval;
        logic [3:0]  waddr;
    } vec_t;

    vec_t vt [11];

    initial begin
        bit ok;
        int s0, w0, f0;
        vt[0]  = '{40'hA5_02_03_7E_7F, 8'h00, 32'h5A_00_7E_7E, 1'b1, 1'b0, 4'd3,  8'h7E, 4'h3};
        vt[1]  = '{40'hA5_01_03_00_02, 8'h00, 32'h5A_00_7E_7E, 1'b0, 1'b0, 4'd3,  8'h7E, 4'h3};
        vt[2]  = '{40'hA5_01_0F_00_0E, 8'hC3, 32'h5A_00_C3_C3, 1'b0, 1'b0, 4'd3,  8'h7E, 4'h3};
        vt[3]  = '{40'hA5_02_0F_11_1C, 8'h00, 32'h5A_02_00_02, 1'b0, 1'b0, 4'd3,  8'h7E, 4'h3};
        vt[4]  = '{40'hA5_02_03_7E_00, 8'h00, 32'h5A_04_00_04, 1'b0, 1'b1, 4'd3,  8'h7E, 4'h3};
        vt[5]  = '{40'hA5_02_00_55_57, 8'h00, 32'h5A_00_55_55, 1'b1, 1'b0, 4'd0,  8'h55, 4'h0};
        vt[6]  = '{40'hA5_01_10_00_11, 8'h00, 32'h5A_03_00_03, 1'b0, 1'b0, 4'd0,  8'h55, 4'h0};
        vt[7]  = '{40'hA5_01_00_00_01, 8'h00, 32'h5A_00_55_55, 1'b0, 1'b0, 4'd3,  8'h7E, 4'h0};
        vt[8]  = '{40'hA5_07_20_00_27, 8'h00, 32'h5A_01_00_01, 1'b0, 1'b0, 4'd0,  8'h55, 4'h0};
        vt[9]  = '{40'hA5_02_0E_9C_90, 8'h00, 32'h5A_00_9C_9C, 1'b1, 1'b0, 4'd14, 8'h9C, 4'hE};
        vt[10] = '{40'hA5_02_01_A5_A6, 8'h00, 32'h5A_00_A5_A5, 1'b1, 1'b0, 4'd1,  8'hA5, 4'h1};

        repeat (3) @(negedge CLK);
        check("rst_regs", REGS_OUT, 120'd0);
        check("rst_txdata", 120'(TX_DATA), 120'd0);
        check("rst_txstart", 120'(TX_START), 120'd0);
        check("rst_wrstrobe", 120'(WR_STROBE), 120'd0);
        check("rst_wraddr", 120'(WR_ADDR), 120'd0);
        check("rst_ferr", 120'(FRAME_ERR), 120'd0);
        check("rst_busy", 120'(BUSY), 120'd0);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        for (int v = 0; v < 11; v++) begin
            STATUS_IN = vt[v].sts;
            txq.delete();
            tx_unstable = 1'b0;
            w0 = n_wr;
            f0 = n_ferr;
            for (int b = 4; b >= 0; b--) send_byte(vt[v].req[8*b +: 8]);
            wait_idle(ok);
            check($sformatf("v%0d_idle", v), 120'(ok), 120'd1);
            check_reply($sformatf("v%0d", v), vt[v].rep);
            check($sformatf("v%0d_wr", v), 120'(n_wr - w0), 120'(vt[v].wr));
            check($sformatf("v%0d_ferr", v), 120'(n_ferr - f0), 120'(vt[v].ferr));
            check($sformatf("v%0d_reg", v), 120'(REGS_OUT[8*vt[v].ridx +: 8]), 120'(vt[v].rval));
            check($sformatf("v%0d_waddr", v), 120'(WR_ADDR), 120'(vt[v].waddr));
        end

        // Leading garbage and transmitter held busy before the reply
        txq.delete();
        tx_unstable = 1'b0;
        s0 = n_start;
        hold_busy = 1'b1;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'hA5);
        send_byte(8'h07);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h06);
        repeat (300) @(negedge CLK);
        check("hold_nostart", 120'(n_start - s0), 120'd0);
        check("hold_busy", 120'(BUSY), 120'd1);
        hold_busy = 1'b0;
        wait_idle(ok);
        check("hold_idle", 120'(ok), 120'd1);
        check_reply("hold", 32'h5A_01_00_01);
        check("hold_nstart", 120'(n_start - s0), 120'd4);

        // Bytes arriving during the reply are dropped
        txq.delete();
        tx_unstable = 1'b0;
        w0 = n_wr;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hA5);
        send_byte(8'hA5);
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h7E);
        wait_idle(ok);
        check("rxdrop_idle", 120'(ok), 120'd1);
        check_reply("rxdrop", 32'h5A_00_55_55);
        check("rxdrop_wr", 120'(n_wr - w0), 120'd0);
        check("rxdrop_reg3", 120'(REGS_OUT[31:24]), 120'h7E);

        // Reset after the second reply byte starts
        txq.delete();
        s0 = n_start;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h02);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge CLK);
            if (n_start - s0 >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        check("rstmid_reach2", 120'(ok), 120'd1);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (200) @(negedge CLK);
        check("rstmid_nstart", 120'(n_start - s0), 120'd2);
        check("rstmid_busy", 120'(BUSY), 120'd0);
        check("rstmid_regs", REGS_OUT, 120'd0);

        // Frame stalls after CMD byte
        txq.delete();
        tx_unstable = 1'b0;
        s0 = n_start;
        f0 = n_ferr;
        send_byte(8'hA5);
        send_byte(8'h02);
        repeat (85) @(negedge CLK);
        check("stall_busy_early", 120'(BUSY), 120'd1);
        repeat (65) @(negedge CLK);
`ifdef UART_RSP_TIMEOUT_EN
        check("to_busy", 120'(BUSY), 120'd0);
        check("to_ferr", 120'(n_ferr - f0), 120'd1);
        check("to_nostart", 120'(n_start - s0), 120'd0);
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h04);
        send_byte(8'h33);
        send_byte(8'h35);
        wait_idle(ok);
        check("to_after_idle", 120'(ok), 120'd1);
        check_reply("to_after", 32'h5A_00_33_33);
        check("to_after_reg4", 120'(REGS_OUT[39:32]), 120'h33);
`else
        check("noto_busy", 120'(BUSY), 120'd1);
        check("noto_ferr", 120'(n_ferr - f0), 120'd0);
        check("noto_nostart", 120'(n_start - s0), 120'd0);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check("noto_rst_busy", 120'(BUSY), 120'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
